// File: rtl/status_led_pkg.sv
// rtl/status_led_pkg.sv - shared types and constants for the status LED driver
package status_led_pkg;

  typedef enum logic [1:0] {LED_OFF, LED_ON, LED_BLINK, LED_PWM} led_mode_t;

  localparam int MS_PER_SEC = 1000;

endpackage

// File: rtl/status_led_if.sv
// rtl/status_led_if.sv - control inputs and LED/timing outputs of the status LED driver
interface status_led_if #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8
);

  logic [2*NUM_LEDS-1:0]        mode;
  logic [PWM_BITS*NUM_LEDS-1:0] duty;
  logic [NUM_LEDS-1:0]          pulse;
  logic [NUM_LEDS-1:0]          led;
  logic                         heartbeat;
  logic                         ms_tick;

  modport master (output mode, duty, pulse, input led, heartbeat, ms_tick);
  modport slave  (input mode, duty, pulse, output led, heartbeat, ms_tick);

endinterface

// File: rtl/status_led_channel.sv
// rtl/status_led_channel.sv - one LED channel: activity stretch, mode mux, polarity, output register
module status_led_channel
  import status_led_pkg::*;
#(
  parameter int STRETCH_MS = 50,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic      clk,
  input  logic      rstN,
  input  led_mode_t mode,
  input  logic      blink_phase,
  input  logic      pwm_lit,
  input  logic      ms_tick,
  input  logic      pulse,
  output logic      led
);

  localparam int SW = $clog2(STRETCH_MS + 1);

  logic [SW-1:0] stretch_cnt;
  logic [SW-1:0] stretch_nxt;
  logic          mode_lit;
  logic          lit;

  // A pulse reload beats a coincident ms_tick so a retrigger always gets a full stretch.
  always_comb begin
    stretch_nxt = stretch_cnt;
    if (pulse) begin
      stretch_nxt = SW'(STRETCH_MS);
    end else if (ms_tick && (stretch_cnt != '0)) begin
      stretch_nxt = stretch_cnt - SW'(1);
    end
  end

  always_comb begin
    mode_lit = 1'b0;
    case (mode)
      LED_OFF:   mode_lit = 1'b0;
      LED_ON:    mode_lit = 1'b1;
      LED_BLINK: mode_lit = blink_phase;
      LED_PWM:   mode_lit = pwm_lit;
      default:   mode_lit = 1'b0;
    endcase
  end

  // Looking at the next counter value keeps the pin one cycle behind pulse.
  assign lit = (stretch_nxt != '0) | mode_lit;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stretch_cnt <= '0;
      led         <= ACTIVE_LOW;
    end else begin
      stretch_cnt <= stretch_nxt;
      led         <= lit ^ ACTIVE_LOW;
    end
  end

endmodule

// File: rtl/status_led_ctrl.sv
// rtl/status_led_ctrl.sv - N-channel status LED driver with ms prescaler, blink phase and heartbeat
// Define STATUS_LED_PWM_EN to build the PWM dimming path; otherwise mode 3 drives the LED on.
module status_led_ctrl
  import status_led_pkg::*;
#(
  parameter int CLK_FREQ        = 50_000_000,
  parameter int NUM_LEDS        = 8,
  parameter int BLINK_PERIOD_MS = 500,
  parameter int STRETCH_MS      = 50,
  parameter int PWM_BITS        = 8,
  parameter int ACTIVE_LOW      = 1
) (
  input logic         clk,
  input logic         rstN,
  status_led_if.slave bus
);

  localparam int P    = CLK_FREQ / MS_PER_SEC;
  localparam int PW   = $clog2(P);
  localparam int HALF = BLINK_PERIOD_MS / 2;
  localparam int MW   = (HALF > 1) ? $clog2(HALF) : 1;

  logic [PW-1:0]       presc;
  logic [MW-1:0]       ms_cnt;
  logic                ms_tick;
  logic                blink_phase;
  logic [NUM_LEDS-1:0] pwm_lit;
  logic [NUM_LEDS-1:0] led_q;

  assign ms_tick = (presc == PW'(P - 1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      presc <= '0;
    end else if (ms_tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ms_cnt      <= '0;
      blink_phase <= 1'b0;
    end else if (ms_tick) begin
      if (ms_cnt == MW'(HALF - 1)) begin
        ms_cnt      <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        ms_cnt <= ms_cnt + MW'(1);
      end
    end
  end

`ifdef STATUS_LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_pwm
    assign pwm_lit[i] = (pwm_cnt < bus.duty[PWM_BITS*i +: PWM_BITS]);
  end
`else
  logic unused_duty;
  assign unused_duty = ^bus.duty;
  assign pwm_lit     = '1;
`endif

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    status_led_channel #(
      .STRETCH_MS (STRETCH_MS),
      .ACTIVE_LOW (ACTIVE_LOW != 0)
    ) u_ch (
      .clk         (clk),
      .rstN        (rstN),
      .mode        (led_mode_t'(bus.mode[2*i +: 2])),
      .blink_phase (blink_phase),
      .pwm_lit     (pwm_lit[i]),
      .ms_tick     (ms_tick),
      .pulse       (bus.pulse[i]),
      .led         (led_q[i])
    );
  end

  assign bus.led       = led_q;
  assign bus.heartbeat = blink_phase;
  assign bus.ms_tick   = ms_tick;

endmodule
